dmem_arbiter: RTL and testbench

Shares the single data memory between `NUM_CORES` matrix-multiplication cores. Each core presents an address, write data and read/write strobes; the arbiter grants one core per access, drives the memory port, and returns read data to the granted core with a per-core valid pulse. It also aggregates the per-core end flags into one system-level done indication.

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one data memory between NUM_CORES cores and aggregates
//            their end flags. Define DMEM_ARB_RR_EN for round-robin
//            arbitration; otherwise the lowest requesting index wins.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        RESET,
    input  logic [NUM_CORES*ADDR_W-1:0] core_ar,
    input  logic [NUM_CORES*DATA_W-1:0] core_dout,
    input  logic [NUM_CORES-1:0]        core_read,
    input  logic [NUM_CORES-1:0]        core_write,
    input  logic [NUM_CORES-1:0]        core_end,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_din,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    output logic                        mem_re,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        all_done
);

    localparam int c_PTR_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_CORES-1:0]   r_gnt, w_gnt_nxt;
    logic [NUM_CORES-1:0]   r_rvalid, w_rvalid_nxt;
    logic [DATA_W-1:0]      r_din, w_din_nxt;
    logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
    logic [DATA_W-1:0]      r_wdata, w_wdata_nxt;
    logic                   r_we, w_we_nxt;
    logic                   r_re, w_re_nxt;
    logic [c_PTR_W-1:0]     r_sel, w_sel_nxt;
    logic                   r_done;

    logic [NUM_CORES-1:0]   w_req;
    logic [c_PTR_W-1:0]     w_ptr;
    logic [c_PTR_W-1:0]     w_win;
    logic                   w_found;

    // Search starts at the pointer and wraps; first active request wins.
    always_comb begin
        w_req   = core_read | core_write;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_found && w_req[(int'(w_ptr) + i) % NUM_CORES]) begin
                w_found = 1'b1;
                w_win   = c_PTR_W'((int'(w_ptr) + i) % NUM_CORES);
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    logic [c_PTR_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_ptr <= '0;
        end else if (r_state == S_IDLE && w_found) begin
            r_ptr <= (int'(w_win) == NUM_CORES - 1) ? '0 : w_win + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = '0;
        w_rvalid_nxt = '0;
        w_we_nxt     = 1'b0;
        w_re_nxt     = 1'b0;
        w_din_nxt    = r_din;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_sel_nxt    = r_sel;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt      = S_ISSUE;
                    w_sel_nxt        = w_win;
                    w_gnt_nxt[w_win] = 1'b1;
                    w_addr_nxt       = core_ar[w_win*ADDR_W +: ADDR_W];
                    w_wdata_nxt      = core_dout[w_win*DATA_W +: DATA_W];
                    // A write strobe takes precedence over a simultaneous read.
                    w_we_nxt         = core_write[w_win];
                    w_re_nxt         = ~core_write[w_win];
                end
            end
            S_ISSUE: begin
                w_state_nxt = r_we ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                w_din_nxt           = mem_rdata;
                w_rvalid_nxt[r_sel] = 1'b1;
                w_state_nxt         = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_din    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_sel    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_din    <= w_din_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_we     <= w_we_nxt;
            r_re     <= w_re_nxt;
            r_sel    <= w_sel_nxt;
            r_done   <= r_done | (&core_end);
        end
    end

    assign core_gnt    = r_gnt;
    assign core_rvalid = r_rvalid;
    assign core_din    = r_din;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_we      = r_we;
    assign mem_re      = r_re;
    assign all_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a registered memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              RESET;
    logic [N*AW-1:0]   core_ar;
    logic [N*DW-1:0]   core_dout;
    logic [N-1:0]      core_read;
    logic [N-1:0]      core_write;
    logic [N-1:0]      core_end;
    logic [N-1:0]      core_gnt;
    logic [N-1:0]      core_rvalid;
    logic [DW-1:0]     core_din;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DW-1:0]     mem_rdata;
    logic              all_done;

    dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .core_ar     (core_ar),
        .core_dout   (core_dout),
        .core_read   (core_read),
        .core_write  (core_write),
        .core_end    (core_end),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_din    (core_din),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .all_done    (all_done)
    );

    always #5 clk = ~clk;

    // Memory model: read data appears the cycle after mem_re.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        core_read  = '0;
        core_write = '0;
    endtask

    task automatic set_core(input int k, input logic rd, input logic wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] data);
        core_ar[k*AW +: AW]   = addr;
        core_dout[k*DW +: DW] = data;
        core_read[k]          = rd;
        core_write[k]         = wr;
    endtask

    task automatic do_reset;
        @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        RESET = 1'b1;
    endtask

    typedef struct {
        int         core;
        logic       rd;
        logic       wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0] exp_gnt;
        logic       exp_we;
        logic       exp_re;
        logic [3:0] exp_rvalid;
        logic [15:0] exp_din;
    } vec_t;

    vec_t vecs [5];
    logic [3:0] exp_g;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[16'h0010] = 16'hBEEF;
        mem_rdata = '0;

        vecs[0] = '{2, 1'b1, 1'b0, 16'h0010, 16'h0000, 4'b0100, 1'b0, 1'b1, 4'b0100, 16'hBEEF};
        vecs[1] = '{1, 1'b1, 1'b1, 16'h0005, 16'h1234, 4'b0010, 1'b1, 1'b0, 4'b0000, 16'hBEEF};
        vecs[2] = '{0, 1'b0, 1'b1, 16'h0020, 16'hA5A5, 4'b0001, 1'b1, 1'b0, 4'b0000, 16'hBEEF};
        vecs[3] = '{3, 1'b1, 1'b0, 16'h0020, 16'h0000, 4'b1000, 1'b0, 1'b1, 4'b1000, 16'hA5A5};
        vecs[4] = '{1, 1'b1, 1'b0, 16'h0005, 16'h0000, 4'b0010, 1'b0, 1'b1, 4'b0010, 16'h1234};

        core_ar   = '0;
        core_dout = '0;
        core_end  = '0;
        idle_inputs();

        // Reset state
        RESET = 1'b0;
        #12;
        chk("rst_gnt",    32'(core_gnt),    32'h0);
        chk("rst_rvalid", 32'(core_rvalid), 32'h0);
        chk("rst_we",     32'(mem_we),      32'h0);
        chk("rst_re",     32'(mem_re),      32'h0);
        chk("rst_addr",   32'(mem_addr),    32'h0);
        chk("rst_wdata",  32'(mem_wdata),   32'h0);
        chk("rst_din",    32'(core_din),    32'h0);
        chk("rst_done",   32'(all_done),    32'h0);
        @(negedge clk);
        RESET = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_gnt", 32'(core_gnt), 32'h0);
            chk("idle_re",  32'(mem_re | mem_we), 32'h0);
        end

        // Single transactions from idle
        for (int v = 0; v < 5; v++) begin
            set_core(vecs[v].core, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].data);
            tick();
            chk("vec_gnt",  32'(core_gnt), 32'(vecs[v].exp_gnt));
            chk("vec_we",   32'(mem_we),   32'(vecs[v].exp_we));
            chk("vec_re",   32'(mem_re),   32'(vecs[v].exp_re));
            chk("vec_addr", 32'(mem_addr), 32'(vecs[v].addr));
            if (vecs[v].wr) chk("vec_wdata", 32'(mem_wdata), 32'(vecs[v].data));
            idle_inputs();
            tick();
            chk("vec_gnt_drop", 32'(core_gnt), 32'h0);
            chk("vec_strobe_off", 32'({mem_we, mem_re}), 32'h0);
            chk("vec_rvalid_early", 32'(core_rvalid), 32'h0);
            if (vecs[v].exp_re) tick();
            chk("vec_rvalid", 32'(core_rvalid), 32'(vecs[v].exp_rvalid));
            chk("vec_din",    32'(core_din),    32'(vecs[v].exp_din));
        end

        // Four cores writing continuously
        do_reset();
        for (int k = 0; k < N; k++) set_core(k, 1'b0, 1'b1, 16'(k), 16'(16'h1000 + k));
        for (int g = 0; g < 6; g++) begin
            tick();
`ifdef DMEM_ARB_RR_EN
            exp_g = 4'b0001 << (g % 4);
`else
            exp_g = 4'b0001;
`endif
            chk("rr_gnt", 32'(core_gnt), 32'(exp_g));
            chk("rr_we",  32'(mem_we),   32'h1);
            chk("rr_wdata", 32'(mem_wdata),
                32'(16'h1000 + ((exp_g == 4'b0001) ? 0 : (exp_g == 4'b0010) ? 1 :
                               (exp_g == 4'b0100) ? 2 : 3)));
            tick();
            chk("rr_gap", 32'(core_gnt), 32'h0);
        end
        idle_inputs();
        tick();

        // Reset during ISSUE of a core-3 read
        set_core(3, 1'b1, 1'b0, 16'h0010, 16'h0000);
        tick();
        chk("mr_gnt", 32'(core_gnt), 32'b1000);
        chk("mr_re",  32'(mem_re),   32'h1);
        #2;
        RESET = 1'b0;
        #1;
        chk("mr_re_clr",   32'(mem_re),   32'h0);
        chk("mr_addr_clr", 32'(mem_addr), 32'h0);
        chk("mr_gnt_clr",  32'(core_gnt), 32'h0);
        chk("mr_din_clr",  32'(core_din), 32'h0);
        idle_inputs();
        @(negedge clk);
        RESET = 1'b1;
        repeat (3) begin
            tick();
            chk("mr_no_rvalid", 32'(core_rvalid), 32'h0);
        end
        set_core(2, 1'b0, 1'b1, 16'h0030, 16'h0002);
        set_core(0, 1'b0, 1'b1, 16'h0031, 16'h0001);
        tick();
        chk("mr_next_gnt", 32'(core_gnt), 32'b0001);
        idle_inputs();
        tick();
        tick();

        // Done aggregation
        core_end = 4'b0001; tick(); chk("done_0001", 32'(all_done), 32'h0);
        core_end = 4'b0011; tick(); chk("done_0011", 32'(all_done), 32'h0);
        core_end = 4'b0111; tick(); chk("done_0111", 32'(all_done), 32'h0);
        core_end = 4'b1111;
        chk("done_before", 32'(all_done), 32'h0);
        tick();
        chk("done_rise", 32'(all_done), 32'h1);
        core_end = 4'b0000;
        tick();
        chk("done_sticky1", 32'(all_done), 32'h1);
        tick();
        chk("done_sticky2", 32'(all_done), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
